// File: rtl/xlib_avalon_pkg.sv
// xlib_avalon_pkg: FSM encoding and beat-to-byte shift helper for the DMA write controller
package xlib_avalon_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t CALC  = 2'd1;
  localparam state_t BURST = 2'd2;
  function automatic int beat_shift(input int dw);
    return $clog2(dw / 8);
  endfunction
endpackage

// File: rtl/xlib_avalon_burst_calc.sv
// xlib_avalon_burst_calc: beats for the next burst, capped at MAXB and the remaining words
// With XLIB_DMA_WCTL_ALIGN_EN defined, bursts also stop at MAXB-beat aligned boundaries
module xlib_avalon_burst_calc
  import xlib_avalon_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int BL   = 8,
  parameter int LW   = 16,
  parameter int MAXB = 8
) (
  input  logic [AW-1:0] addr,
  input  logic [LW-1:0] remaining,
  output logic [BL-1:0] b
);
  logic [LW-1:0] lim;
`ifdef XLIB_DMA_WCTL_ALIGN_EN
  localparam int SH = beat_shift(DW);
  logic [LW-1:0] beat_idx;
  assign beat_idx = LW'((addr >> SH) & AW'(MAXB - 1));
  assign lim = LW'(MAXB) - beat_idx;
`else
  logic unused_addr;
  assign unused_addr = ^addr;
  assign lim = LW'(MAXB);
`endif
  assign b = BL'(remaining < lim ? remaining : lim);
endmodule

// File: rtl/xlib_avalon_dma_wctl.sv
// xlib_avalon_dma_wctl: splits a write command into bursts on an arbiter slave port
// Optional XLIB_DMA_WCTL_ALIGN_EN keeps bursts inside MAXB-beat aligned windows
module xlib_avalon_dma_wctl
  import xlib_avalon_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int BL   = 8,
  parameter int LW   = 16,
  parameter int MAXB = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_val,
  output logic          cmd_rdy,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          d_val,
  output logic          d_rdy,
  input  logic [DW-1:0] d_data,
  input  logic          m_wrdy,
  output logic          m_wval,
  output logic [BL-1:0] m_wlen,
  output logic [AW-1:0] m_waddr,
  output logic [DW-1:0] m_wdata,
  output logic          busy,
  output logic          done
);
  localparam int SH = beat_shift(DW);
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, waddr_q, waddr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [BL-1:0] cnt_q, cnt_d, wlen_q, wlen_d, b;
  logic done_q, done_d, beat, last;
  xlib_avalon_burst_calc #(.DW(DW), .AW(AW), .BL(BL), .LW(LW), .MAXB(MAXB)) u_calc (
    .addr(addr_q),
    .remaining(rem_q),
    .b(b)
  );
  assign cmd_rdy = state_q == IDLE;
  assign busy    = state_q != IDLE;
  assign m_wval  = (state_q == BURST) && d_val;
  assign d_rdy   = (state_q == BURST) && m_wrdy;
  assign m_wdata = d_data;
  assign m_wlen  = wlen_q;
  assign m_waddr = waddr_q;
  assign done    = done_q;
  assign beat    = m_wval && m_wrdy;
  assign last    = beat && (cnt_q == wlen_q);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    wlen_d  = wlen_q;
    waddr_d = waddr_q;
    done_d  = 1'b0;
    if (state_q == IDLE && cmd_val) begin
      addr_d  = cmd_addr;
      rem_d   = cmd_len;
      state_d = (cmd_len != '0) ? CALC : IDLE;
      done_d  = cmd_len == '0;
    end
    if (state_q == CALC) begin
      wlen_d  = b;
      waddr_d = addr_q;
      cnt_d   = BL'(1);
      state_d = BURST;
    end
    if (beat) cnt_d = cnt_q + BL'(1);
    if (last) begin
      rem_d   = rem_q - LW'(wlen_q);
      addr_d  = addr_q + (AW'(wlen_q) << SH);
      state_d = (rem_d != '0) ? CALC : IDLE;
      done_d  = rem_d == '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      wlen_q  <= '0;
      waddr_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      wlen_q  <= wlen_d;
      waddr_q <= waddr_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_xlib_avalon_dma_wctl.sv
// tb_xlib_avalon_dma_wctl: directed checks of burst splitting, stalls, zero length and reset abort
module tb_xlib_avalon_dma_wctl;
  logic clk = 1'b0;
  logic rst_n;
  logic cmd_val, cmd_rdy, d_val, d_rdy, m_wrdy, m_wval, busy, done;
  logic [31:0] cmd_addr, d_data, m_waddr, m_wdata;
  logic [15:0] cmd_len;
  logic [7:0] m_wlen;
  int pass = 0;
  int total = 0;
  int n, done_cnt, done_t, acc_t, fwv_t, proto_bad, err;
  logic [31:0] base;
  logic [31:0] bdata[64];
  logic [31:0] baddr[64];
  logic [7:0] blen[64];

  xlib_avalon_dma_wctl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .d_val(d_val), .d_rdy(d_rdy), .d_data(d_data),
    .m_wrdy(m_wrdy), .m_wval(m_wval), .m_wlen(m_wlen), .m_waddr(m_waddr), .m_wdata(m_wdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic run(input logic [31:0] a, input logic [15:0] l, input bit wtog, input bit drnd, input int stop);
    bit took, fin;
    int s, len;
    took = 0; fin = 0; n = 0; done_cnt = 0; done_t = -1; acc_t = -1; fwv_t = -1; proto_bad = 0;
    base = 32'hA000_0000 + a;
    d_data = base;
    for (int t = 0; t < 400 && !fin; t++) begin
      @(posedge clk); #1;
      if (took) d_data = d_data + 1;
      cmd_val = (t == 0); cmd_addr = a; cmd_len = l;
      m_wrdy = wtog ? (t % 2 == 0) : 1'b1;
      d_val = drnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (cmd_val && cmd_rdy && acc_t < 0) acc_t = t;
      if (m_wval && fwv_t < 0) fwv_t = t;
      if (m_wval && d_rdy !== m_wrdy) proto_bad++;
      if (!busy && (m_wval || d_rdy)) proto_bad++;
      took = m_wval && m_wrdy;
      if (took && n < 64) begin
        bdata[n] = m_wdata; blen[n] = m_wlen; baddr[n] = m_waddr; n++;
      end
      if (done) begin done_cnt++; done_t = t; fin = 1; end
      if (stop > 0 && n >= stop) fin = 1;
    end
    cmd_val = 1'b0;
    s = 0;
    while (s < n) begin
      len = int'(blen[s]);
      if (len == 0) begin proto_bad++; break; end
      for (int j = s; j < s + len && j < n; j++)
        if (blen[j] !== blen[s] || baddr[j] !== baddr[s]) proto_bad++;
      s += len;
    end
    err = 0;
    for (int k = 0; k < n; k++) if (bdata[k] !== base + k) err++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_val = 0; cmd_addr = 0; cmd_len = 0; d_val = 0; d_data = 0; m_wrdy = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (cmd_rdy !== 1'b1) $display("FAIL reset_cmd_rdy got=%b want=1", cmd_rdy); else pass++;
    total++; if (m_wval !== 1'b0) $display("FAIL reset_m_wval got=%b want=0", m_wval); else pass++;
    total++; if (d_rdy !== 1'b0) $display("FAIL reset_d_rdy got=%b want=0", d_rdy); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else pass++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else pass++;
    total++; if (m_wlen !== 8'd0) $display("FAIL reset_m_wlen got=%0d want=0", m_wlen); else pass++;
    total++; if (m_waddr !== 32'd0) $display("FAIL reset_m_waddr got=%h want=0", m_waddr); else pass++;
  endtask

  task automatic test_split();
    run(32'h0, 16'd20, 0, 0, 0);
    total++; if (n !== 20) $display("FAIL split_beats got=%0d want=20", n); else pass++;
    total++; if (done_cnt !== 1) $display("FAIL split_done got=%0d want=1", done_cnt); else pass++;
    total++; if (fwv_t - acc_t !== 2) $display("FAIL split_latency got=%0d want=2", fwv_t - acc_t); else pass++;
    total++; if (blen[0] !== 8'd8 || baddr[0] !== 32'h00) $display("FAIL split_b0 got=%0d@%h want=8@00", blen[0], baddr[0]); else pass++;
    total++; if (blen[8] !== 8'd8 || baddr[8] !== 32'h20) $display("FAIL split_b1 got=%0d@%h want=8@20", blen[8], baddr[8]); else pass++;
    total++; if (blen[16] !== 8'd4 || baddr[16] !== 32'h40) $display("FAIL split_b2 got=%0d@%h want=4@40", blen[16], baddr[16]); else pass++;
    total++; if (err !== 0) $display("FAIL split_data errors=%0d want=0", err); else pass++;
    total++; if (proto_bad !== 0) $display("FAIL split_protocol errors=%0d want=0", proto_bad); else pass++;
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL split_after done=%b busy=%b want=0 0", done, busy); else pass++;
  endtask

  task automatic test_align();
    run(32'h18, 16'd10, 0, 0, 0);
    total++; if (n !== 10) $display("FAIL align_beats got=%0d want=10", n); else pass++;
`ifdef XLIB_DMA_WCTL_ALIGN_EN
    total++; if (blen[0] !== 8'd2 || baddr[0] !== 32'h18) $display("FAIL align_b0 got=%0d@%h want=2@18", blen[0], baddr[0]); else pass++;
    total++; if (blen[2] !== 8'd8 || baddr[2] !== 32'h20) $display("FAIL align_b1 got=%0d@%h want=8@20", blen[2], baddr[2]); else pass++;
`else
    total++; if (blen[0] !== 8'd8 || baddr[0] !== 32'h18) $display("FAIL align_b0 got=%0d@%h want=8@18", blen[0], baddr[0]); else pass++;
    total++; if (blen[8] !== 8'd2 || baddr[8] !== 32'h38) $display("FAIL align_b1 got=%0d@%h want=2@38", blen[8], baddr[8]); else pass++;
`endif
    total++; if (err !== 0 || proto_bad !== 0) $display("FAIL align_stream data=%0d proto=%0d want=0 0", err, proto_bad); else pass++;
  endtask

  task automatic test_zero_len();
    run(32'h100, 16'd0, 0, 0, 0);
    total++; if (done_cnt !== 1) $display("FAIL zero_done got=%0d want=1", done_cnt); else pass++;
    total++; if (done_t - acc_t !== 1) $display("FAIL zero_done_delay got=%0d want=1", done_t - acc_t); else pass++;
    total++; if (fwv_t !== -1) $display("FAIL zero_wval got=%0d want=-1", fwv_t); else pass++;
    total++; if (cmd_rdy !== 1'b1 || busy !== 1'b0) $display("FAIL zero_idle cmd_rdy=%b busy=%b want=1 0", cmd_rdy, busy); else pass++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL zero_pulse got=%b want=0", done); else pass++;
  endtask

  task automatic test_stall();
    run(32'h1000, 16'd13, 1, 1, 0);
    total++; if (n !== 13) $display("FAIL stall_beats got=%0d want=13", n); else pass++;
    total++; if (err !== 0) $display("FAIL stall_data errors=%0d want=0", err); else pass++;
    total++; if (proto_bad !== 0) $display("FAIL stall_protocol errors=%0d want=0", proto_bad); else pass++;
    total++; if (done_cnt !== 1) $display("FAIL stall_done got=%0d want=1", done_cnt); else pass++;
    total++; if (blen[0] !== 8'd8 || baddr[0] !== 32'h1000) $display("FAIL stall_b0 got=%0d@%h want=8@1000", blen[0], baddr[0]); else pass++;
    total++; if (blen[8] !== 8'd5 || baddr[8] !== 32'h1020) $display("FAIL stall_b1 got=%0d@%h want=5@1020", blen[8], baddr[8]); else pass++;
  endtask

  task automatic test_reset_mid();
    run(32'h200, 16'd8, 0, 0, 3);
    total++; if (n !== 3 || m_wval !== 1'b1) $display("FAIL mid_setup beats=%0d wval=%b want=3 1", n, m_wval); else pass++;
    rst_n = 1'b0;
    #1;
    total++; if (m_wval !== 1'b0 || d_rdy !== 1'b0) $display("FAIL mid_rst_handshake wval=%b d_rdy=%b want=0 0", m_wval, d_rdy); else pass++;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mid_rst_status busy=%b done=%b want=0 0", busy, done); else pass++;
    total++; if (cmd_rdy !== 1'b1) $display("FAIL mid_rst_cmd_rdy got=%b want=1", cmd_rdy); else pass++;
    total++; if (m_wlen !== 8'd0 || m_waddr !== 32'd0) $display("FAIL mid_rst_burst got=%0d@%h want=0@0", m_wlen, m_waddr); else pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL mid_abandon done=%b busy=%b want=0 0", done, busy); else pass++;
    run(32'h300, 16'd4, 0, 0, 0);
    total++; if (n !== 4) $display("FAIL mid_new_beats got=%0d want=4", n); else pass++;
    total++; if (blen[0] !== 8'd4 || baddr[0] !== 32'h300) $display("FAIL mid_new_burst got=%0d@%h want=4@300", blen[0], baddr[0]); else pass++;
    total++; if (done_cnt !== 1 || err !== 0) $display("FAIL mid_new_done done=%0d data_err=%0d want=1 0", done_cnt, err); else pass++;
  endtask

  initial begin
    test_reset();
    test_split();
    test_align();
    test_zero_len();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
